// File: rtl/tdc_sample_accum.sv
// -----------------------------------------------------------------------------
// tdc_sample_accum
//
// Accumulates bursts of S = 2**LOG2_S popcount samples coming from a TDC
// delay-line encoder and presents the burst sum and truncated average to a
// downstream consumer through a valid/ready handshake.
//
// Parameters
//   N       TDC delay-line width; popcount samples range 0..N
//   LOG2_S  log2 of samples per burst (legal 1..8)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous reset, active low
//   start      pulse that begins a new burst (restarts an active burst)
//   cont       continuous mode: re-arm automatically after each handshake
//   in_valid   popcount sample strobe
//   in_data    popcount sample, W = $clog2(N)+1 bits
//   out_valid  burst result available
//   out_ready  consumer accepts the result
//   out_sum    sum of the S samples of the burst, W+LOG2_S bits
//   out_avg    out_sum >> LOG2_S, truncated to W bits
//   busy       high while a burst is being accumulated
//   overrun    sticky flag: a sample arrived while a result was pending
//   out_min    smallest sample of the burst   (TDC_ACC_MINMAX_EN only)
//   out_max    largest sample of the burst    (TDC_ACC_MINMAX_EN only)
//
// Build options
//   TDC_ACC_MINMAX_EN  when defined, adds per-burst min/max trackers and the
//                      out_min/out_max ports. Without it the block has no
//                      min/max logic at all.
// -----------------------------------------------------------------------------
module tdc_sample_accum #(
    parameter int N      = 64,
    parameter int LOG2_S = 4,
    localparam int W     = $clog2(N) + 1,
    localparam int SW    = W + LOG2_S,
    localparam int CW    = LOG2_S + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [W-1:0]  out_avg,
    output logic          busy,
    output logic          overrun
`ifdef TDC_ACC_MINMAX_EN
    ,
    output logic [W-1:0]  out_min,
    output logic [W-1:0]  out_max
`endif
);

    // Index of the last sample of a burst, as seen by the sample counter
    // before it is incremented.
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG2_S) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [SW-1:0]  sum;
    logic [SW-1:0]  sum_next;
    logic [SW-1:0]  sum_plus;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [SW-1:0]  out_sum_next;
    logic [W-1:0]   out_avg_next;
    logic           overrun_next;

    // Datapath control decoded by the FSM.
    logic           take_sample;
    logic           latch_result;
    logic           clear_burst;
    logic           last_sample;

    // The running sum including the sample on the input this cycle; this is
    // both the accumulator update and the value latched on the last sample.
    assign sum_plus    = sum + SW'(in_data);
    assign last_sample = (count == LAST_IDX);

    assign busy      = (state == ACCUM);
    assign out_valid = (state == HOLD);

    // Next-state and datapath control. A start during ACCUM takes priority
    // over a same-cycle sample so the restarted burst begins empty. In HOLD
    // the result registers are not touched, so start and stray samples
    // cannot disturb the pending result; stray samples only raise overrun.
    always_comb begin
        state_next   = state;
        overrun_next = overrun;
        take_sample  = 1'b0;
        latch_result = 1'b0;
        clear_burst  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ACCUM;
                    clear_burst  = 1'b1;
                    overrun_next = 1'b0;
                end
            end

            ACCUM: begin
                if (start) begin
                    clear_burst = 1'b1;
                end else if (in_valid) begin
                    take_sample = 1'b1;
                    if (last_sample) begin
                        latch_result = 1'b1;
                        clear_burst  = 1'b1;
                        state_next   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (in_valid) begin
                    overrun_next = 1'b1;
                end
                if (out_ready) begin
                    if (cont) begin
                        state_next  = ACCUM;
                        clear_burst = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next  = IDLE;
                clear_burst = 1'b1;
            end
        endcase
    end

    // Accumulator, sample counter and result register next values.
    always_comb begin
        sum_next     = sum;
        count_next   = count;
        out_sum_next = out_sum;
        out_avg_next = out_avg;

        if (take_sample) begin
            sum_next   = sum_plus;
            count_next = count + CW'(1);
        end

        if (clear_burst) begin
            sum_next   = '0;
            count_next = '0;
        end

        if (latch_result) begin
            out_sum_next = sum_plus;
            out_avg_next = sum_plus[SW-1:LOG2_S];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, counter, result and overrun registers. Reset discards any
    // partial burst and any pending result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum     <= '0;
            count   <= '0;
            out_sum <= '0;
            out_avg <= '0;
            overrun <= 1'b0;
        end else begin
            sum     <= sum_next;
            count   <= count_next;
            out_sum <= out_sum_next;
            out_avg <= out_avg_next;
            overrun <= overrun_next;
        end
    end

`ifdef TDC_ACC_MINMAX_EN
    localparam logic [W-1:0] N_W = W'(N);

    logic [W-1:0] cur_min;
    logic [W-1:0] cur_max;
    logic [W-1:0] cur_min_next;
    logic [W-1:0] cur_max_next;
    logic [W-1:0] sample_min;
    logic [W-1:0] sample_max;
    logic [W-1:0] out_min_next;
    logic [W-1:0] out_max_next;

    // Extremes including the current sample. The first sample of a burst
    // (count == 0) loads both trackers regardless of their previous contents.
    always_comb begin
        sample_min = cur_min;
        sample_max = cur_max;
        if (count == '0) begin
            sample_min = in_data;
            sample_max = in_data;
        end else begin
            if (in_data < cur_min) begin
                sample_min = in_data;
            end
            if (in_data > cur_max) begin
                sample_max = in_data;
            end
        end
    end

    // Tracker and output register next values, following the same
    // take/clear/latch decode as the accumulator.
    always_comb begin
        cur_min_next = cur_min;
        cur_max_next = cur_max;
        out_min_next = out_min;
        out_max_next = out_max;

        if (take_sample) begin
            cur_min_next = sample_min;
            cur_max_next = sample_max;
        end

        if (clear_burst) begin
            cur_min_next = N_W;
            cur_max_next = '0;
        end

        if (latch_result) begin
            out_min_next = sample_min;
            out_max_next = sample_max;
        end
    end

    // Min/max registers; reset leaves min at full scale and max at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_min <= N_W;
            cur_max <= '0;
            out_min <= N_W;
            out_max <= '0;
        end else begin
            cur_min <= cur_min_next;
            cur_max <= cur_max_next;
            out_min <= out_min_next;
            out_max <= out_max_next;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_sample_accum.sv
// -----------------------------------------------------------------------------
// tb_tdc_sample_accum
//
// Directed self-checking bench for tdc_sample_accum with N=64, LOG2_S=2
// (four samples per burst). Inputs are driven 1 time unit after the rising
// edge and outputs are sampled at the same point, away from the active edge.
// All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_tdc_sample_accum;

    localparam int N      = 64;
    localparam int LOG2_S = 2;
    localparam int W      = $clog2(N) + 1;
    localparam int SW     = W + LOG2_S;

    logic          clk;
    logic          rst;
    logic          start;
    logic          cont;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic [W-1:0]  out_avg;
    logic          busy;
    logic          overrun;
`ifdef TDC_ACC_MINMAX_EN
    logic [W-1:0]  out_min;
    logic [W-1:0]  out_max;
`endif

    int checkCount;
    int errorCount;

    tdc_sample_accum #(
        .N      (N),
        .LOG2_S (LOG2_S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .busy      (busy),
        .overrun   (overrun)
`ifdef TDC_ACC_MINMAX_EN
        ,
        .out_min   (out_min),
        .out_max   (out_max)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to 1 unit past the next edge.
    task automatic applyStimulus(input logic st, input logic ct, input logic vld,
                                 input int data, input logic rdy);
        start     = st;
        cont      = ct;
        in_valid  = vld;
        in_data   = W'(data);
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int samplesA[4];
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_overrun",   32'(overrun),   32'd0);
        checkOutput("rst_out_sum",   32'(out_sum),   32'd0);
        checkOutput("rst_out_avg",   32'(out_avg),   32'd0);
`ifdef TDC_ACC_MINMAX_EN
        checkOutput("rst_out_min",   32'(out_min),   32'd64);
        checkOutput("rst_out_max",   32'(out_max),   32'd0);
`endif
        rst = 1'b1;

        // Samples in IDLE are ignored.
        applyStimulus(0, 0, 1, 33, 0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);

        // Basic burst 10,20,30,41 -> 101 / 25.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("b1_busy", 32'(busy), 32'd1);
        samplesA = '{10, 20, 30, 41};
        for (int i = 0; i < 4; i++) begin
            checkOutput("b1_valid_early", 32'(out_valid), 32'd0);
            applyStimulus(0, 0, 1, samplesA[i], 0);
        end
        checkOutput("b1_valid",   32'(out_valid), 32'd1);
        checkOutput("b1_busy_hold", 32'(busy),    32'd0);
        checkOutput("b1_sum",     32'(out_sum),   32'd101);
        checkOutput("b1_avg",     32'(out_avg),   32'd25);
`ifdef TDC_ACC_MINMAX_EN
        checkOutput("b1_min",     32'(out_min),   32'd10);
        checkOutput("b1_max",     32'(out_max),   32'd41);
`endif

        // Backpressure: result held for 5 cycles, then handshake to IDLE.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_sum",   32'(out_sum),   32'd101);
            checkOutput("bp_avg",   32'(out_avg),   32'd25);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("hs_valid", 32'(out_valid), 32'd0);
        checkOutput("hs_busy",  32'(busy),      32'd0);
        applyStimulus(0, 0, 1, 7, 0);
        checkOutput("hs_idle_busy", 32'(busy), 32'd0);

        // Overrun in HOLD, start ignored in HOLD.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 2, 0);
        applyStimulus(0, 0, 1, 3, 0);
        applyStimulus(0, 0, 1, 4, 0);
        checkOutput("ov_sum_pre", 32'(out_sum), 32'd10);
        checkOutput("ov_avg_pre", 32'(out_avg), 32'd2);
        checkOutput("ov_flag_pre", 32'(overrun), 32'd0);
        applyStimulus(0, 0, 1, 5, 0);
        checkOutput("ov_flag",  32'(overrun),   32'd1);
        checkOutput("ov_sum",   32'(out_sum),   32'd10);
        checkOutput("ov_valid", 32'(out_valid), 32'd1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("hold_start_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_start_sum",   32'(out_sum),   32'd10);
        checkOutput("hold_start_busy",  32'(busy),      32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ov_sticky", 32'(overrun), 32'd1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ov_clear", 32'(overrun), 32'd0);

        // Restart mid-burst: same-cycle sample not counted.
        applyStimulus(0, 0, 1, 9, 0);
        applyStimulus(0, 0, 1, 9, 0);
        applyStimulus(1, 0, 1, 50, 0);
        checkOutput("rs_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 1, 0);
        end
        checkOutput("rs_valid", 32'(out_valid), 32'd1);
        checkOutput("rs_sum",   32'(out_sum),   32'd4);
        checkOutput("rs_avg",   32'(out_avg),   32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rs_hs_valid", 32'(out_valid), 32'd0);

        // Continuous mode: two back-to-back full-scale bursts.
        applyStimulus(1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 64, 1);
        end
        checkOutput("c1_valid", 32'(out_valid), 32'd1);
        checkOutput("c1_sum",   32'(out_sum),   32'd256);
        checkOutput("c1_avg",   32'(out_avg),   32'd64);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("c1_rearm_busy",  32'(busy),      32'd1);
        checkOutput("c1_rearm_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 64, 1);
        end
        checkOutput("c2_valid", 32'(out_valid), 32'd1);
        checkOutput("c2_sum",   32'(out_sum),   32'd256);
        checkOutput("c2_avg",   32'(out_avg),   32'd64);
        checkOutput("c2_overrun", 32'(overrun), 32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("c_end_busy",  32'(busy),      32'd0);
        checkOutput("c_end_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset between clock edges during ACCUM.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 20, 0);
        applyStimulus(0, 0, 1, 30, 0);
        start    = 1'b0;
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        checkOutput("ar_busy",  32'(busy),      32'd0);
        checkOutput("ar_valid", 32'(out_valid), 32'd0);
        checkOutput("ar_sum",   32'(out_sum),   32'd0);
        checkOutput("ar_avg",   32'(out_avg),   32'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ar_idle_busy", 32'(busy), 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 0);
        applyStimulus(0, 0, 1, 5, 0);
        applyStimulus(0, 0, 1, 7, 0);
        applyStimulus(0, 0, 1, 9, 0);
        checkOutput("ar_b_valid", 32'(out_valid), 32'd1);
        checkOutput("ar_b_sum",   32'(out_sum),   32'd24);
        checkOutput("ar_b_avg",   32'(out_avg),   32'd6);
`ifdef TDC_ACC_MINMAX_EN
        checkOutput("ar_b_min",   32'(out_min),   32'd3);
        checkOutput("ar_b_max",   32'(out_max),   32'd9);
`endif
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ar_b_hs", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
